// File: rtl/mux4_rr_sched.sv
// ---------------------------------------------------------------------------
// mux4_rr_sched
// Control stage in front of a combinational 32-bit 4:1 mux (A0..A3 -> C).
// It arbitrates among four requesters, drives the mux selects, waits a
// programmable settle time and then captures C into an output register that
// has a valid/ready handshake. The result is a flow-controlled 4-to-1 merger.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [3:0] requester i has stable data on mux input Ai
//   req_ready  out  [3:0] one-hot, one cycle: Ai consumed at that edge
//   sel1       out  mux select MSB
//   sel2       out  mux select LSB ({sel1,sel2} = channel index)
//   mux_c      in   [DATA_W-1:0] mux output C
//   out_valid  out  out_data holds a captured word
//   out_ready  in   downstream accepts out_data
//   out_data   out  [DATA_W-1:0] captured word
//   out_src    out  [1:0] channel that produced out_data
//
// Parameters
//   DATA_W  width of mux_c / out_data (must match the mux)
//   SETTLE  cycles the select is held before capture, 1..15
//
// Build option
//   MUX4_FIXED_PRIO_EN  defined   : fixed priority ch3 > ch2 > ch1 > ch0
//                       undefined : round-robin (default)
//
// FSM states
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no transaction; selects hold their last value
//   ST_SETTLE  | select driven, counting down; capture when count hits 0
//   ST_OUT     | out_data valid, waiting for out_ready
// ---------------------------------------------------------------------------
module mux4_rr_sched #(
    parameter int DATA_W = 32,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_valid,
    output logic [3:0]        req_ready,
    output logic              sel1,
    output logic              sel2,
    input  logic [DATA_W-1:0] mux_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_src_q, out_src_d;
    logic [1:0]        winner;
    logic              any_req;

    assign any_req = |req_valid;

`ifdef MUX4_FIXED_PRIO_EN
    // Fixed priority: the highest-numbered requesting channel wins.
    always_comb begin
        winner = 2'd0;
        if (req_valid[3])      winner = 2'd3;
        else if (req_valid[2]) winner = 2'd2;
        else if (req_valid[1]) winner = 2'd1;
    end
`else
    logic [1:0] ptr_q, ptr_d;

    // Scan ptr+1, ptr+2, ptr+3, ptr+4 (mod 4). Iterating from the far end
    // down lets the nearest requesting channel overwrite the result last.
    always_comb begin
        logic [1:0] idx;
        winner = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr_q + 2'(k);
            if (req_valid[idx]) winner = idx;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
`ifndef MUX4_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    sel_d   = winner;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    out_data_d  = mux_c;
                    out_src_d   = sel_q;
                    out_valid_d = 1'b1;
`ifndef MUX4_FIXED_PRIO_EN
                    ptr_d       = sel_q;
`endif
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (any_req) begin
                        // Back-to-back: re-arbitrate on the same edge the
                        // current word is accepted.
                        sel_d   = winner;
                        cnt_d   = CNT_INIT;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
`ifndef MUX4_FIXED_PRIO_EN
            ptr_q       <= 2'd3;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
`ifndef MUX4_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Decoded purely from registers, so the pulse cannot glitch and lasts
    // exactly the one cycle that ends in the capture edge.
    always_comb begin
        req_ready = 4'b0000;
        if (state_q == ST_SETTLE && cnt_q == 4'd0) begin
            req_ready = 4'b0001 << sel_q;
        end
    end

    assign sel1      = sel_q[1];
    assign sel2      = sel_q[0];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid, req_valid3;
    logic [3:0]  req_ready, req_ready3;
    logic        sel1, sel2, sel1_3, sel2_3;
    logic [31:0] mux_c, mux_c3;
    logic        out_valid, out_valid3;
    logic        out_ready, out_ready3;
    logic [31:0] out_data, out_data3;
    logic [1:0]  out_src, out_src3;

    logic [31:0] a_data [4];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the downstream combinational mux.
    assign mux_c  = a_data[{sel1, sel2}];
    assign mux_c3 = a_data[{sel1_3, sel2_3}];

    mux4_rr_sched #(.DATA_W(32), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .sel1(sel1), .sel2(sel2), .mux_c(mux_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    mux4_rr_sched #(.DATA_W(32), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .sel1(sel1_3), .sel2(sel2_3), .mux_c(mux_c3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_src(out_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef MUX4_FIXED_PRIO_EN
    int rr_exp [5]  = '{3, 3, 3, 3, 3};
    int bp_next     = 3;
    int first_1001  = 3;
    int p5_exp [3]  = '{2, 2, 2};
`else
    int rr_exp [5]  = '{0, 1, 2, 3, 0};
    int bp_next     = 1;
    int first_1001  = 0;
    int p5_exp [3]  = '{2, 0, 2};
`endif

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        req_valid3 = 4'b0000;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        a_data[0] = 32'd0; a_data[1] = 32'd0; a_data[2] = 32'd0; a_data[3] = 32'd0;

        // ---------------- reset ----------------
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        check("rst_sel",       32'({sel1, sel2}), 32'd0);
        check("rst_req_ready", 32'(req_ready),    32'd0);
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_out_data",  out_data,          32'd0);
        check("rst_out_src",   32'(out_src),      32'd0);

        // ---------------- single request, ch3 ----------------
        a_data[3] = 32'd3;
        req_valid = 4'b1000;
        tick();
        check("single_sel",       32'({sel1, sel2}), 32'd3);
        check("single_req_ready", 32'(req_ready),    32'h8);
        check("single_ov_early",  32'(out_valid),    32'd0);
        tick();
        check("single_out_valid", 32'(out_valid),    32'd1);
        check("single_out_data",  out_data,          32'd3);
        check("single_out_src",   32'(out_src),      32'd3);
        check("single_rr_clear",  32'(req_ready),    32'd0);
        req_valid = 4'b0000;
        tick();
        check("single_ov_drop",   32'(out_valid),    32'd0);
        check("single_sel_hold",  32'({sel1, sel2}), 32'd3);

        // ---------------- round robin, all requesting ----------------
        a_data[0] = 32'd2; a_data[1] = 32'd3; a_data[2] = 32'd2; a_data[3] = 32'd3;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_sel",       32'({sel1, sel2}), 32'(rr_exp[i]));
            check("rr_req_ready", 32'(req_ready),    32'(4'b0001 << rr_exp[i]));
            check("rr_ov_low",    32'(out_valid),    32'd0);
            tick();
            check("rr_out_valid", 32'(out_valid),    32'd1);
            check("rr_out_data",  out_data,          a_data[rr_exp[i]]);
            check("rr_out_src",   32'(out_src),      32'(rr_exp[i]));
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid),    32'd1);
            check("bp_out_data",  out_data,          a_data[rr_exp[4]]);
            check("bp_sel",       32'({sel1, sel2}), 32'(rr_exp[4]));
            check("bp_req_ready", 32'(req_ready),    32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_sel",   32'({sel1, sel2}), 32'(bp_next));
        check("bp_next_ready", 32'(req_ready),    32'(4'b0001 << bp_next));
        tick();
        check("bp_next_src",   32'(out_src),      32'(bp_next));
        req_valid = 4'b0000;
        tick();
        check("bp_idle_ov",    32'(out_valid),    32'd0);

        // ---------------- async reset while in OUT ----------------
        a_data[2] = 32'h77;
        req_valid = 4'b0100;
        out_ready = 1'b0;
        tick();
        tick();
        req_valid = 4'b0000;
        check("mid_ov_before", 32'(out_valid), 32'd1);
        check("mid_od_before", out_data,       32'h77);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_ov",    32'(out_valid),    32'd0);
        check("mid_rst_od",    out_data,          32'd0);
        check("mid_rst_src",   32'(out_src),      32'd0);
        check("mid_rst_sel",   32'({sel1, sel2}), 32'd0);
        check("mid_rst_ready", 32'(req_ready),    32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // ptr must be back at 3 after reset, so ch0 beats ch3 (round-robin)
        a_data[0] = 32'd10; a_data[2] = 32'd20; a_data[3] = 32'd30;
        req_valid = 4'b1001;
        tick();
        check("ptr_rst_sel", 32'({sel1, sel2}), 32'(first_1001));
        tick();
        check("ptr_rst_src", 32'(out_src),      32'(first_1001));
        check("ptr_rst_od",  out_data,          a_data[first_1001]);

        // ---------------- req_valid = 0101 held ----------------
        req_valid = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p5_sel",  32'({sel1, sel2}), 32'(p5_exp[i]));
            tick();
            check("p5_src",  32'(out_src),      32'(p5_exp[i]));
            check("p5_data", out_data,          a_data[p5_exp[i]]);
        end
        req_valid = 4'b0000;
        tick();
        check("p5_idle_ov", 32'(out_valid), 32'd0);

        // ---------------- SETTLE = 3 instance ----------------
        a_data[1] = 32'h55;
        req_valid3 = 4'b0010;
        tick();
        check("s3_sel_n0",   32'({sel1_3, sel2_3}), 32'd1);
        check("s3_ready_n0", 32'(req_ready3),       32'd0);
        tick();
        check("s3_sel_n1",   32'({sel1_3, sel2_3}), 32'd1);
        check("s3_ready_n1", 32'(req_ready3),       32'd0);
        check("s3_ov_n1",    32'(out_valid3),       32'd0);
        tick();
        check("s3_sel_n2",   32'({sel1_3, sel2_3}), 32'd1);
        check("s3_ready_n2", 32'(req_ready3),       32'h2);
        check("s3_ov_n2",    32'(out_valid3),       32'd0);
        tick();
        check("s3_ov_n3",    32'(out_valid3),       32'd1);
        check("s3_data",     out_data3,             32'h55);
        check("s3_src",      32'(out_src3),         32'd1);
        check("s3_ready_n3", 32'(req_ready3),       32'd0);
        req_valid3 = 4'b0000;
        tick();
        check("s3_idle_ov",  32'(out_valid3),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
